write_buffer: RTL and testbench
===============================

WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 xbar_wbuf_valid_i  input  1  xbar write beat valid.
REQ-004 xbar_wbuf_ready_o  output  1  write beat accepted (free entry exists in addressed channel).
REQ-005 xbar_wbuf_channel_id_i  input  2  target channel.
REQ-006 xbar_wbuf_data_i  input  128  write data beat.
REQ-007 wbuf_xbar_alloc_id_o  output  8  entry id allocated to this beat, valid while valid_i&ready_o.
REQ-008 rc_wbuf_req_valid_i  input  1  sram controller read request valid.
REQ-009 rc_wbuf_req_ready_o  output  1  read request accepted.
REQ-010 rc_wbuf_req_channel_id_i  input  2  channel of entry to read.
REQ-011 rc_wbuf_req_wbuffer_id_i  input  8  entry id to read.
REQ-012 rc_wbuf_rtn_valid_o  output  1  return data valid.
REQ-013 rc_wbuf_rtn_ready_i  input  1  sram controller accepts return data.
REQ-014 rc_wbuf_rtn_data_o  output  128  return data.
REQ-015 wbuf_full_o  output  4  per-channel full flag (all 16 entries occupied).
REQ-016 wbuf_rd_err_o  output  1  one-cycle pulse, read of unoccupied/out-of-range entry (WBUF_RD_ERR_CHK_EN only).

Function
REQ-017 Storage SHALL be 4 channels x 16 entries x 128 bit, plus one occupied bit per entry.
REQ-018 xbar_wbuf_ready_o SHALL be 1 iff the addressed channel has at least one clear occupied bit (registered bitmap, no same-cycle reuse of freed entries).
REQ-019 Allocation SHALL pick the lowest-index free entry; alloc_id = {4'b0, index}.
REQ-020 On write handshake, data SHALL be stored and occupied bit set on that clock edge.
REQ-021 rc_wbuf_req_ready_o SHALL equal !rc_wbuf_rtn_valid_o | rc_wbuf_rtn_ready_i (single output register, full throughput).
REQ-022 On read handshake, rtn_data SHALL load entry data and rtn_valid set on the next edge (latency 1); occupied bit cleared on the same edge.
REQ-023 rtn_valid_o SHALL clear on rtn handshake with no new request; rtn_data_o SHALL hold stable while valid & !ready.
REQ-024 Simultaneous write (entry X) and read-free (entry Y) in one channel SHALL both take effect; Y not allocatable until next cycle.
REQ-025 Read of unoccupied entry or id[7:4]!=0 SHALL still handshake and return entry[id[3:0]] contents; occupied bitmap unchanged for id[7:4]!=0.
REQ-026 wbuf_full_o[c] SHALL be the AND of channel c occupied bits.

Reset
REQ-027 rst_n low SHALL clear all occupied bits, rtn_valid_o=0, rtn_data_o=0, wbuf_rd_err_o=0, regardless of in-flight handshake.
REQ-028 Data storage SHALL not be reset; outputs after reset: xbar_wbuf_ready_o=1, rc_wbuf_req_ready_o=1, wbuf_full_o=4'b0.

Configuration
REQ-029 WBUF_RD_ERR_CHK_EN defined: wbuf_rd_err_o pulses one cycle, aligned with rtn_valid rise, for REQ-025 cases.
REQ-030 WBUF_RD_ERR_CHK_EN undefined: wbuf_rd_err_o tied 0, no check logic.

Structure
REQ-031 Package wbuf_pkg SHALL hold WBUF_CH_NUM=4, WBUF_DEPTH=16, WBUF_IDX_W=4, WBUF_ID_W=8, WBUF_DATA_W=128.
REQ-032 Sub-module wbuf_free_pick SHALL implement the 16-bit lowest-free priority encoder plus any-free flag, one instance per channel.

Verification
REQ-033 Reset, write ch1 data 0xA5.. -> alloc_id 0x00; second write ch1 -> 0x01; read ch1 id 0x00 -> rtn_data 0xA5.. one cycle after request.
REQ-034 16 writes to ch2 -> wbuf_full_o=4'b0100, ready_o=0 for ch2, ready_o=1 for ch0.
REQ-035 Full ch2, read id 0x05 and write ch2 same cycle -> write stalls that cycle, next cycle accepted with alloc_id 0x05.
REQ-036 rtn_ready_i=0 for 3 cycles with back-to-back requests -> req_ready_o=0, rtn_data_o stable, no loss; release -> one beat per cycle.
REQ-037 Read ch0 id 0x13 with WBUF_RD_ERR_CHK_EN -> wbuf_rd_err_o=1 one cycle, bitmap unchanged; without macro -> 0.
REQ-038 rst_n asserted while rtn_valid_o=1 -> rtn_valid_o=0 immediately, full flags 0, alloc restarts at 0x00.

Source files
------------

// File: rtl/wbuf_pkg.sv
// wbuf_pkg: shared geometry constants for the write buffer
package wbuf_pkg;
  localparam int WBUF_CH_NUM = 4;
  localparam int WBUF_CH_W   = 2;
  localparam int WBUF_DEPTH  = 16;
  localparam int WBUF_IDX_W  = 4;
  localparam int WBUF_ID_W   = 8;
  localparam int WBUF_DATA_W = 128;
endpackage

// File: rtl/wbuf_free_pick.sv
// wbuf_free_pick: lowest-index free entry priority encoder with any-free flag
module wbuf_free_pick
  import wbuf_pkg::*;
(
  input  logic [WBUF_DEPTH-1:0] free,
  output logic [WBUF_IDX_W-1:0] idx,
  output logic                  any
);
  // scan from the top so the lowest set bit is the last one to win
  always_comb begin
    idx = '0;
    for (int i = WBUF_DEPTH - 1; i >= 0; i--) if (free[i]) idx = WBUF_IDX_W'(i);
  end
  assign any = |free;
endmodule

// File: rtl/write_buffer.sv
// write_buffer: per-channel entry store with lowest-free allocation and one-register read return; optional read-error check under WBUF_RD_ERR_CHK_EN
module write_buffer
  import wbuf_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   xbar_wbuf_valid_i,
  output logic                   xbar_wbuf_ready_o,
  input  logic [WBUF_CH_W-1:0]   xbar_wbuf_channel_id_i,
  input  logic [WBUF_DATA_W-1:0] xbar_wbuf_data_i,
  output logic [WBUF_ID_W-1:0]   wbuf_xbar_alloc_id_o,
  input  logic                   rc_wbuf_req_valid_i,
  output logic                   rc_wbuf_req_ready_o,
  input  logic [WBUF_CH_W-1:0]   rc_wbuf_req_channel_id_i,
  input  logic [WBUF_ID_W-1:0]   rc_wbuf_req_wbuffer_id_i,
  output logic                   rc_wbuf_rtn_valid_o,
  input  logic                   rc_wbuf_rtn_ready_i,
  output logic [WBUF_DATA_W-1:0] rc_wbuf_rtn_data_o,
  output logic [WBUF_CH_NUM-1:0] wbuf_full_o,
  output logic                   wbuf_rd_err_o
);
  logic [WBUF_CH_NUM-1:0][WBUF_DEPTH-1:0] occ;
  logic [WBUF_DATA_W-1:0] mem [WBUF_CH_NUM][WBUF_DEPTH];
  logic [WBUF_CH_NUM-1:0][WBUF_IDX_W-1:0] pick;
  logic [WBUF_CH_NUM-1:0] any;
  logic [WBUF_IDX_W-1:0] wr_idx, rd_idx;
  logic wr_fire, rd_fire, rd_in_range;

  genvar c;
  generate
    for (c = 0; c < WBUF_CH_NUM; c++) begin : g_ch
      wbuf_free_pick u_pick (.free(~occ[c]), .idx(pick[c]), .any(any[c]));
      assign wbuf_full_o[c] = &occ[c];
    end
  endgenerate

  assign xbar_wbuf_ready_o    = any[xbar_wbuf_channel_id_i];
  assign wr_idx               = pick[xbar_wbuf_channel_id_i];
  assign wbuf_xbar_alloc_id_o = {{(WBUF_ID_W - WBUF_IDX_W){1'b0}}, wr_idx};
  assign wr_fire              = xbar_wbuf_valid_i & xbar_wbuf_ready_o;
  assign rd_idx               = rc_wbuf_req_wbuffer_id_i[WBUF_IDX_W-1:0];
  assign rd_in_range          = rc_wbuf_req_wbuffer_id_i[WBUF_ID_W-1:WBUF_IDX_W] == '0;
  assign rc_wbuf_req_ready_o  = !rc_wbuf_rtn_valid_o | rc_wbuf_rtn_ready_i;
  assign rd_fire              = rc_wbuf_req_valid_i & rc_wbuf_req_ready_o;

  // data array is not reset; written on the allocating edge
  always_ff @(posedge clk)
    if (wr_fire) mem[xbar_wbuf_channel_id_i][wr_idx] <= xbar_wbuf_data_i;

  // occupancy: read frees (in-range ids only), write sets; set wins if both hit one bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) occ <= '0;
    else begin
      if (rd_fire && rd_in_range) occ[rc_wbuf_req_channel_id_i][rd_idx] <= 1'b0;
      if (wr_fire) occ[xbar_wbuf_channel_id_i][wr_idx] <= 1'b1;
    end

  // single return register: load on request, drop when drained with nothing new
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rc_wbuf_rtn_valid_o <= 1'b0;
      rc_wbuf_rtn_data_o  <= '0;
    end else if (rd_fire) begin
      rc_wbuf_rtn_valid_o <= 1'b1;
      rc_wbuf_rtn_data_o  <= mem[rc_wbuf_req_channel_id_i][rd_idx];
    end else if (rc_wbuf_rtn_ready_i) rc_wbuf_rtn_valid_o <= 1'b0;

`ifdef WBUF_RD_ERR_CHK_EN
  // flag reads of free or out-of-range entries alongside their return beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wbuf_rd_err_o <= 1'b0;
    else wbuf_rd_err_o <= rd_fire && (!rd_in_range || !occ[rc_wbuf_req_channel_id_i][rd_idx]);
`else
  assign wbuf_rd_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: directed + mixed stimulus against a queue/array model of the write buffer
module tb_write_buffer;
  logic clk = 1'b0, rst_n;
  logic xv, xready, rv, req_ready, rtn_valid, rtn_ready, rd_err;
  logic [1:0] xch, rch;
  logic [127:0] xdata, rtn_data;
  logic [7:0] alloc, rid;
  logic [3:0] full;

  write_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .xbar_wbuf_valid_i(xv), .xbar_wbuf_ready_o(xready),
    .xbar_wbuf_channel_id_i(xch), .xbar_wbuf_data_i(xdata),
    .wbuf_xbar_alloc_id_o(alloc),
    .rc_wbuf_req_valid_i(rv), .rc_wbuf_req_ready_o(req_ready),
    .rc_wbuf_req_channel_id_i(rch), .rc_wbuf_req_wbuffer_id_i(rid),
    .rc_wbuf_rtn_valid_o(rtn_valid), .rc_wbuf_rtn_ready_i(rtn_ready),
    .rc_wbuf_rtn_data_o(rtn_data), .wbuf_full_o(full), .wbuf_rd_err_o(rd_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  bit m_occ [4][16];
  bit m_known [4][16];
  logic [127:0] m_mem [4][16];
  bit m_rv, m_rdknown, m_err;
  logic [127:0] m_rdata;

`ifdef WBUF_RD_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h @%0t", n, a, e, $time);
    end
  endtask

  function automatic int lowest_free(int ch);
    for (int i = 0; i < 16; i++) if (!m_occ[ch][i]) return i;
    return -1;
  endfunction

  // model compare and advance, once per cycle on the falling edge
  always @(negedge clk) begin
    int lf;
    bit rd, e;
    logic [3:0] fexp;
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) for (int i = 0; i < 16; i++) m_occ[c][i] = 1'b0;
      m_rv = 1'b0; m_rdata = '0; m_rdknown = 1'b1; m_err = 1'b0;
    end
    lf = lowest_free(int'(xch));
    for (int c = 0; c < 4; c++) begin
      fexp[c] = 1'b1;
      for (int i = 0; i < 16; i++) if (!m_occ[c][i]) fexp[c] = 1'b0;
    end
    chk("xbar_ready", 128'(xready), 128'(lf >= 0));
    if (xv && lf >= 0) chk("alloc_id", 128'(alloc), 128'(lf));
    chk("req_ready", 128'(req_ready), 128'(!m_rv || rtn_ready));
    chk("rtn_valid", 128'(rtn_valid), 128'(m_rv));
    if (m_rdknown) chk("rtn_data", rtn_data, m_rdata);
    chk("full", 128'(full), 128'(fexp));
    chk("rd_err", 128'(rd_err), 128'(m_err));
    if (rst_n) begin
      rd = rv && (!m_rv || rtn_ready);
      e = 1'b0;
      if (rd) begin
        e = (rid[7:4] != 0) || !m_occ[rch][rid[3:0]];
        m_rdata = m_mem[rch][rid[3:0]];
        m_rdknown = m_known[rch][rid[3:0]];
        m_rv = 1'b1;
        if (rid[7:4] == 0) m_occ[rch][rid[3:0]] = 1'b0;
      end else if (rtn_ready) m_rv = 1'b0;
      m_err = ERR_EN && e;
      if (xv && lf >= 0) begin
        m_mem[xch][lf] = xdata;
        m_known[xch][lf] = 1'b1;
        m_occ[xch][lf] = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) for (int i = 0; i < 16; i++) m_known[c][i] = 1'b0;
    rst_n = 1'b0; xv = 0; xch = 0; xdata = '0; rv = 0; rch = 0; rid = 0; rtn_ready = 1;
    step(); step();
    rst_n = 1'b1;
    #1 chk("rst_xready", 128'(xready), 128'd1);
    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_full", 128'(full), 128'd0);
    step();
    // first writes and read-back
    xv = 1; xch = 1; xdata = {16{8'hA5}};
    #1 chk("t1_alloc0", 128'(alloc), 128'h00);
    step();
    xdata = {16{8'h5A}};
    #1 chk("t1_alloc1", 128'(alloc), 128'h01);
    step();
    xv = 0; rv = 1; rch = 1; rid = 8'h00;
    step();
    rv = 0;
    #1 chk("t1_rtn_valid", 128'(rtn_valid), 128'd1);
    chk("t1_rtn_data", rtn_data, {16{8'hA5}});
    step();
    // fill channel 2
    xv = 1; xch = 2;
    for (int i = 0; i < 16; i++) begin
      xdata = {8'hC2, 120'(i)};
      #1 chk("t2_alloc", 128'(alloc), 128'(i));
      step();
    end
    xv = 0;
    #1 chk("t2_full", 128'(full), 128'b0100);
    chk("t2_ready_ch2", 128'(xready), 128'd0);
    xch = 0;
    #1 chk("t2_ready_ch0", 128'(xready), 128'd1);
    // free entry 5 while a write to the full channel waits
    xch = 2; xv = 1; xdata = {8'hD5, 120'h0}; rv = 1; rch = 2; rid = 8'h05;
    #1 chk("t3_stall", 128'(xready), 128'd0);
    step();
    rv = 0;
    #1 chk("t3_ready", 128'(xready), 128'd1);
    chk("t3_alloc5", 128'(alloc), 128'h05);
    step();
    xv = 0;
    #1 chk("t3_refull", 128'(full), 128'b0100);
    step();
    // backpressure on the return path
    rtn_ready = 0; rv = 1; rch = 2; rid = 8'h00;
    step();
    rid = 8'h01;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4_req_ready", 128'(req_ready), 128'd0);
      chk("t4_hold", rtn_data, {8'hC2, 120'd0});
      step();
    end
    rtn_ready = 1;
    #1 chk("t4_release", 128'(req_ready), 128'd1);
    step();
    #1 chk("t4_beat1", rtn_data, {8'hC2, 120'd1});
    rid = 8'h02;
    step();
    rid = 8'h03;
    step();
    rv = 0;
    #1 chk("t4_beat3", rtn_data, {8'hC2, 120'd3});
    step();
    #1 chk("t4_drain", 128'(rtn_valid), 128'd0);
    // out-of-range and unoccupied reads
    xv = 1; xch = 0;
    for (int i = 0; i < 4; i++) begin
      xdata = {8'hE0, 120'(i)};
      step();
    end
    xv = 0; rv = 1; rch = 0;
    for (int i = 0; i < 4; i++) begin
      rid = 8'(i);
      step();
    end
    rid = 8'h13;
    step();
    rv = 0;
    #1 chk("t5_oor_data", rtn_data, {8'hE0, 120'd3});
    chk("t5_oor_err", 128'(rd_err), 128'(ERR_EN));
    step();
    #1 chk("t5_err_pulse", 128'(rd_err), 128'd0);
    rv = 1; rch = 1; rid = 8'h11;
    step();
    rid = 8'h02; rch = 0;
    step();
    rv = 0; xv = 1; xch = 1; xdata = '1;
    #1 chk("t5_alloc0", 128'(alloc), 128'h00);
    step();
    #1 chk("t5_alloc2", 128'(alloc), 128'h02);
    step();
    xv = 0;
    // mixed traffic
    for (int k = 0; k < 400; k++) begin
      xv = 1'($urandom);
      xch = 2'($urandom);
      xdata = {$urandom, $urandom, $urandom, $urandom};
      rv = 1'($urandom);
      rch = 2'($urandom);
      rid = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      rtn_ready = $urandom_range(0, 3) != 0;
      step();
    end
    // reset with a return beat pending
    xv = 0; rv = 0; rtn_ready = 1;
    step();
    rst_n = 0;
    step();
    rst_n = 1; xv = 1; xch = 3; xdata = {16{8'h3C}};
    step();
    xv = 0; rv = 1; rch = 3; rid = 8'h00; rtn_ready = 0;
    step();
    rv = 0;
    #1 chk("t6_valid_before", 128'(rtn_valid), 128'd1);
    rst_n = 0;
    #1 chk("t6_valid_cleared", 128'(rtn_valid), 128'd0);
    chk("t6_full", 128'(full), 128'd0);
    chk("t6_data", rtn_data, 128'd0);
    step();
    rst_n = 1; rtn_ready = 1; xv = 1; xch = 1; xdata = {16{8'h77}};
    #1 chk("t6_alloc_restart", 128'(alloc), 128'h00);
    step();
    xv = 0;
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
